// File: rtl/mm_seq_pkg.sv
// ---------------------------------------------------------------------------
// mm_seq_pkg : shared types and constants for the matrix-multiply sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4,
    TX    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BAD_CMD = 2'b01,
    ERR_OVERRUN = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  localparam logic [7:0] OP_LOAD_RUN  = 8'hA5;
  localparam logic [7:0] OP_RERUN     = 8'h5A;
  localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;

  // Counter/address widths never collapse to zero bits for tiny configurations.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mm_tx_byte_sender.sv
// ---------------------------------------------------------------------------
// mm_tx_byte_sender : serialises a result word MSB-first onto the UART TX
// handshake, inserting a guard cycle after every tx_start.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mm_tx_byte_sender
  import mm_seq_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = clog2_min1(ACC_W / 8 + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] word,
  input  logic [CNT_W-1:0] nbytes,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             done
);

  logic [ACC_W-1:0] shreg;
  logic [CNT_W-1:0] remaining;
  logic             can_send;

  // tx_start being high this cycle is the guard: the UART has not yet raised busy.
  assign can_send = !tx_busy && !tx_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      remaining <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        if (can_send) begin
          tx_data   <= word[ACC_W-1 -: 8];
          shreg     <= word << 8;
          remaining <= nbytes - CNT_W'(1);
          tx_start  <= 1'b1;
          done      <= (nbytes == CNT_W'(1));
        end else begin
          shreg     <= word;
          remaining <= nbytes;
        end
      end else if (remaining != '0 && can_send) begin
        tx_data   <= shreg[ACC_W-1 -: 8];
        shreg     <= shreg << 8;
        remaining <= remaining - CNT_W'(1);
        tx_start  <= 1'b1;
        done      <= (remaining == CNT_W'(1));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mm_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// mm_cmd_sequencer : UART command parser / operand loader / result streamer
// for the matrix-multiply array.  Optional MULT_DONE watchdog: MMSEQ_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mm_cmd_sequencer
  import mm_seq_pkg::*;
#(
  parameter int DIM            = 2,
  parameter int DATA_W         = 8,
  parameter int ACC_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LA_W           = clog2_min1(2 * DIM * DIM),
  parameter int RA_W           = clog2_min1(DIM * DIM)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              load_arr,
  output logic [LA_W-1:0]   load_addr,
  output logic [DATA_W-1:0] load_data,
  output logic              mult_start,
  input  logic              mult_done,
  output logic [RA_W-1:0]   res_addr,
  input  logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic [1:0]        err_code
);

  localparam int N_OPS = 2 * DIM * DIM;
  localparam int N_RES = DIM * DIM;
  localparam int BYTES = ACC_W / 8;
  localparam int CNT_W = clog2_min1(BYTES + 1);

  state_t           state;
  err_t             err;
  logic [LA_W-1:0]  cnt;
  logic             timeout_hit;
  logic             timeout_fire;
  logic             rx_overrun;
  logic             snd_load;
  logic             snd_done;
  logic [ACC_W-1:0] snd_word;
  logic [CNT_W-1:0] snd_nbytes;

  assign busy       = (state != IDLE);
  assign err_code   = err;
  assign rx_overrun = rx_valid && (state inside {START, WAIT, READ, TX});

`ifdef MMSEQ_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wait_cnt;

  assign timeout_fire = (state == WAIT) && !mult_done &&
                        (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_fire   = 1'b0;
`endif

  // The sender samples res_data directly in READ so the first byte leaves
  // two cycles after mult_done.
  assign snd_load   = (state == READ) || timeout_fire;
  assign snd_word   = timeout_fire ? (ACC_W'(TIMEOUT_BYTE) << (ACC_W - 8)) : res_data;
  assign snd_nbytes = timeout_fire ? CNT_W'(1) : CNT_W'(BYTES);

  mm_tx_byte_sender #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_sender (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (snd_load),
    .word     (snd_word),
    .nbytes   (snd_nbytes),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (snd_done)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      err         <= ERR_OK;
      cnt         <= '0;
      timeout_hit <= 1'b0;
      load_arr    <= 1'b0;
      load_addr   <= '0;
      load_data   <= '0;
      mult_start  <= 1'b0;
      res_addr    <= '0;
    end else begin
      load_arr   <= 1'b0;
      mult_start <= 1'b0;

      // Overrun is applied first so a same-cycle timeout still wins.
      if (rx_overrun && err != ERR_TIMEOUT) begin
        err <= ERR_OVERRUN;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == OP_LOAD_RUN) begin
              state <= LOAD;
              cnt   <= '0;
              err   <= ERR_OK;
            end else if (rx_data == OP_RERUN) begin
              state <= START;
              err   <= ERR_OK;
            end else if (err == ERR_OK) begin
              err <= ERR_BAD_CMD;
            end
          end
        end
        LOAD: begin
          if (rx_valid) begin
            load_arr  <= 1'b1;
            load_addr <= cnt;
            load_data <= DATA_W'(rx_data);
            cnt       <= cnt + LA_W'(1);
            if (cnt == LA_W'(N_OPS - 1)) begin
              state <= START;
            end
          end
        end
        START: begin
          mult_start  <= 1'b1;
          timeout_hit <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            res_addr <= '0;
            state    <= READ;
          end else if (timeout_fire) begin
            err         <= ERR_TIMEOUT;
            timeout_hit <= 1'b1;
            state       <= TX;
          end
        end
        READ: begin
          state <= TX;
        end
        TX: begin
          if (snd_done) begin
            if (timeout_hit || res_addr == RA_W'(N_RES - 1)) begin
              state <= IDLE;
            end else begin
              res_addr <= res_addr + RA_W'(1);
              state    <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mm_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mm_cmd_sequencer : scoreboard bench with array/UART models; the timeout
// scenario is included when MMSEQ_TIMEOUT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mm_cmd_sequencer;

  localparam int DIM   = 2;
  localparam int N_OPS = 2 * DIM * DIM;
  localparam int N_RES = DIM * DIM;
  localparam int BYTES = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        load_arr;
  logic [2:0]  load_addr;
  logic [7:0]  load_data;
  logic        mult_start;
  logic        mult_done = 1'b0;
  logic [1:0]  res_addr;
  logic [15:0] res_data;
  logic        busy;
  logic [1:0]  err_code;

  mm_cmd_sequencer #(
    .DIM(DIM), .DATA_W(8), .ACC_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .load_arr(load_arr), .load_addr(load_addr), .load_data(load_data),
    .mult_start(mult_start), .mult_done(mult_done), .res_addr(res_addr),
    .res_data(res_data), .busy(busy), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rx_cyc = 0;
  int done_cyc = 0;
  int done_delay = 3;
  int done_timer = 0;
  int busy_cnt = 0;
  int exp_starts = 0;
  int tx_seen = 0;
  bit lat_armed = 1'b0;

  logic [7:0]  cur_ops [N_OPS];
  logic [7:0]  arr_ops [N_OPS];
  logic [15:0] arr_res [N_RES];
  logic [7:0]  tx_q [$];
  logic [15:0] ld_q [$];

  assign res_data = arr_res[res_addr];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected strobe with value %0h, none outstanding (cycle %0d)", name, val, cyc);
  endtask

  function automatic void matmul(input logic [7:0] ops [N_OPS], output logic [15:0] res [N_RES]);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        int acc = 0;
        for (int k = 0; k < DIM; k++) begin
          acc += int'(ops[i*DIM + k]) * int'(ops[DIM*DIM + k*DIM + j]);
        end
        res[i*DIM + j] = 16'(acc);
      end
    end
  endfunction

  // UART TX model: busy rises the cycle after tx_start and lasts a few cycles.
  always @(negedge CLK) begin
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
    if (tx_start) busy_cnt = $urandom_range(2, 6);
  end

  // Array model: captures operands, pulses mult_done done_delay cycles after start.
  always @(negedge CLK) begin
    mult_done = 1'b0;
    if (!RESET) begin
      done_timer = 0;
    end else begin
      if (load_arr) arr_ops[load_addr] = load_data;
      if (mult_start) begin
        done_timer = done_delay;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          matmul(arr_ops, arr_res);
          mult_done = 1'b1;
          done_cyc  = cyc;
          lat_armed = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (RESET) begin
      if (load_arr) begin
        if (ld_q.size() == 0) unexpected("load_arr", {load_addr, load_data});
        else begin
          logic [15:0] e;
          e = ld_q.pop_front();
          check("load_addr", load_addr, e[15:8]);
          check("load_data", load_data, e[7:0]);
        end
      end
      if (mult_start) begin
        if (exp_starts == 0) unexpected("mult_start", 1);
        else begin
          exp_starts--;
          check("cmd_to_mult_start_cycles", cyc - last_rx_cyc, 2);
        end
      end
      if (tx_start) begin
        tx_seen++;
        if (tx_q.size() == 0) unexpected("tx_start", tx_data);
        else check("tx_byte", tx_data, tx_q.pop_front());
        if (lat_armed) begin
          check("done_to_tx_start_cycles", cyc - done_cyc, 2);
          lat_armed = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  task automatic push_results();
    logic [15:0] res [N_RES];
    matmul(cur_ops, res);
    for (int r = 0; r < N_RES; r++) begin
      for (int b = BYTES - 1; b >= 0; b--) tx_q.push_back(8'(res[r] >> (8 * b)));
    end
  endtask

  task automatic run_load();
    for (int i = 0; i < N_OPS; i++) ld_q.push_back({8'(i), cur_ops[i]});
    exp_starts++;
    push_results();
    send(8'hA5);
    for (int i = 0; i < N_OPS; i++) send(cur_ops[i]);
  endtask

  task automatic run_rerun();
    exp_starts++;
    push_results();
    send(8'h5A);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || tx_busy || tx_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, busy=%0b pending_tx=%0d", budget, busy, tx_q.size());
    end
    repeat (2) @(negedge CLK);
    check("busy_after_run", busy, 0);
    check("loads_outstanding", ld_q.size(), 0);
    check("starts_outstanding", exp_starts, 0);
  endtask

  initial begin
    RESET    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < N_RES; i++) arr_res[i] = 16'h0;
    for (int i = 0; i < N_OPS; i++) arr_ops[i] = 8'h0;
    repeat (3) @(negedge CLK);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_load_arr", load_arr, 0);
    check("rst_mult_start", mult_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err_code", err_code, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Reference vector: 1..8 -> [19,22,43,50]
    for (int i = 0; i < N_OPS; i++) cur_ops[i] = 8'(i + 1);
    done_delay = 3;
    run_load();
    wait_idle(400);
    check("err_after_load_run", err_code, 2'b00);

    done_delay = 5;
    run_rerun();
    wait_idle(400);

    send(8'h33);
    check("err_bad_cmd", err_code, 2'b01);
    check("busy_after_bad_cmd", busy, 0);
    for (int i = 0; i < N_OPS; i++) cur_ops[i] = 8'($urandom_range(0, 255));
    done_delay = 2;
    run_load();
    wait_idle(400);
    check("err_cleared_by_opcode", err_code, 2'b00);

    // Overrun during WAIT
    done_delay = 25;
    run_load();
    repeat (4) @(negedge CLK);
    send(8'h11);
    check("err_overrun", err_code, 2'b10);
    wait_idle(400);
    check("err_overrun_sticky", err_code, 2'b10);
    send(8'h33);
    check("err_overrun_beats_bad_cmd", err_code, 2'b10);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N_OPS; i++) cur_ops[i] = 8'($urandom_range(0, 255));
      done_delay = $urandom_range(1, 8);
      run_load();
      wait_idle(400);
      check("err_random_run", err_code, 2'b00);
      if ($urandom_range(0, 1) == 1) begin
        done_delay = $urandom_range(1, 8);
        run_rerun();
        wait_idle(400);
      end
    end

`ifdef MMSEQ_TIMEOUT_EN
    done_delay = 0;
    exp_starts++;
    tx_q.push_back(8'hEE);
    send(8'h5A);
    wait_idle(200);
    check("err_timeout", err_code, 2'b11);
    send(8'h33);
    check("err_timeout_beats_bad_cmd", err_code, 2'b11);
    done_delay = 2;
    run_load();
    wait_idle(400);
    check("err_cleared_after_timeout", err_code, 2'b00);
`endif

    // Reset pulse mid-TX after the third byte
    begin
      int base;
      int n;
      for (int i = 0; i < N_OPS; i++) cur_ops[i] = 8'($urandom_range(0, 255));
      done_delay = 2;
      base = tx_seen;
      run_load();
      n = 0;
      while (tx_seen < base + 3 && n < 300) begin
        @(negedge CLK);
        n++;
      end
      if (n >= 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL mid_tx_wait: only %0d bytes seen, expected 3", tx_seen - base);
      end
      @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      check("arst_tx_start", tx_start, 0);
      check("arst_tx_data", tx_data, 0);
      check("arst_load_arr", load_arr, 0);
      check("arst_load_addr", load_addr, 0);
      check("arst_load_data", load_data, 0);
      check("arst_mult_start", mult_start, 0);
      check("arst_res_addr", res_addr, 0);
      check("arst_busy", busy, 0);
      check("arst_err_code", err_code, 0);
      tx_q.delete();
      ld_q.delete();
      exp_starts = 0;
      lat_armed  = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      repeat (30) @(negedge CLK);
      check("post_reset_busy", busy, 0);
      check("post_reset_err", err_code, 0);
    end

    for (int i = 0; i < N_OPS; i++) cur_ops[i] = 8'($urandom_range(0, 255));
    done_delay = 4;
    run_load();
    wait_idle(400);
    check("tx_outstanding_final", tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
